digit_classifier: RTL and testbench
===================================

# digit_classifier

Downstream sequencer and argmax stage for the multiplier block. On `start` it issues one `begin_mult` per weight row (0..NUM_ROWS-1) and holds `row_select` stable while each row computes. It captures each `row_result` on `done_row` and keeps a running signed maximum. After the last row it publishes the winning row index as the classified digit.

## Interface
- `NUM_ROWS`, default 10: number of weight rows / output classes; legal range 2..16.
- `TIMEOUT`, default 1023: maximum WAIT cycles per row before the block flags an error.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin classification. Sampled only in IDLE or ERROR.
- `done_row` in 1: multiplier row-complete pulse.
- `row_result` in 16: multiplier row sum, interpreted as signed two's complement.
- `begin_mult` out 1: one-cycle pulse to the multiplier.
- `row_select` out 4: current row index to the multiplier.
- `busy` out 1: high in ISSUE, WAIT and COMPARE.
- `result_valid` out 1: one-cycle pulse when `digit` and `max_score` update.
- `digit` out 4: winning row index, held until the next completed run.
- `max_score` out 16: winning row_result, held until the next completed run.
- `timeout_err` out 1: sticky error flag, cleared by `start` or reset.

## Operation
- States:
  - IDLE: `start` → ISSUE; set `row_idx`=0 and clear `timeout_err`.
  - ISSUE: `begin_mult`=1 (Moore output); clear watchdog; → WAIT.
  - WAIT:
    - `done_row` → latch `row_result` into `score_reg`, → COMPARE.
    - Else if watchdog == TIMEOUT → ERROR.
    - Else watchdog increments.
  - COMPARE:
    - If `row_idx`==0, or `score_reg` > `best_score` (signed, strict): `best_score`←`score_reg`, `best_idx`←`row_idx`.
    - If `row_idx`==NUM_ROWS-1 → DONE; else `row_idx`++ and → ISSUE.
  - DONE: `digit`←`best_idx`, `max_score`←`best_score`; `result_valid`=1 for one cycle; → IDLE.
  - ERROR: `timeout_err`=1; `digit` and `max_score` keep their previous values. `start` → ISSUE with `row_idx`=0 and clears `timeout_err`.
- `row_select` = `row_idx` and stays stable from ISSUE through COMPARE. The multiplier computes addresses combinationally from it, so it must not change mid-row.
- Ties: the lowest index wins, because the comparison is strict `>`.
- `start` while `busy` is ignored.
- `done_row` in IDLE, ISSUE, COMPARE, DONE or ERROR is ignored.
- A `done_row` arriving on the same cycle the watchdog reaches TIMEOUT has priority: the row is accepted, no error.
- Watchdog width is `$clog2(TIMEOUT+1)` bits; it never wraps (it saturates via the ERROR transition).
- Reset mid-operation: return to IDLE immediately and drive all outputs to their reset values. The multiplier shares `n_rst`, so there is no handshake cleanup.

## Timing
- Reset values:
  - `begin_mult`=0, `row_select`=0, `busy`=0.
  - `result_valid`=0, `digit`=0, `max_score`=0, `timeout_err`=0.
- `start` sampled at edge k → `begin_mult` high in cycle k+1 (ISSUE).
- Per row: 1 cycle ISSUE, plus W cycles in WAIT, including the cycle `done_row` is seen, plus 1 cycle COMPARE.
- Total run = sum of (2+W_i) over the rows, then 1 DONE cycle. `result_valid` is high during DONE.
- `digit` and `max_score` change only on the edge entering DONE's output cycle. They are registered, with no combinational path from `row_result`.
- Worst case before ERROR: entry to WAIT + TIMEOUT cycles, then `timeout_err` high the next cycle.

## Test plan
- Results [5,9,3,9,0,1,2,8,7,4], done_row 3 cycles after each begin_mult → 10 begin_mult pulses with row_select 0..9 in order; result_valid once; digit=1, max_score=9 (tie resolved to lower index).
- All results negative (0xFFF0 … with row 6 = 0xFFFF) → digit=6, max_score=0xFFFF. Confirms the compare is signed.
- Row 4 never returns done_row, TIMEOUT=20 → timeout_err high 21 cycles after WAIT entry; busy=0; digit and max_score unchanged. A subsequent start clears timeout_err and completes normally.
- start pulsed during row 2 WAIT, plus a stray done_row while in IDLE → no restart and no extra begin_mult; results identical to the run without the extra pulses.
- n_rst asserted during row 5 WAIT → all outputs 0 within the same cycle. After release plus start, the sequence restarts at row_select=0.
- done_row on the exact cycle the watchdog == TIMEOUT → row accepted, timeout_err stays 0.

Source files
------------

// File: rtl/digit_classifier.sv
// Sequencer and signed argmax stage for the multiplier block: issues one row at a time,
// tracks the running maximum, and publishes the winning row index.
module digit_classifier #(
  parameter int unsigned NUM_ROWS = 10,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        done_row,
  input  logic [15:0] row_result,
  output logic        begin_mult,
  output logic [3:0]  row_select,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  digit,
  output logic [15:0] max_score,
  output logic        timeout_err
);

  localparam int unsigned WdW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);
  localparam logic [3:0] LastRow = 4'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StCompare, StDone, StError
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     row_idx_q, row_idx_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic [15:0]    score_q, score_d;
  logic [15:0]    best_score_q, best_score_d;
  logic [3:0]     best_idx_q, best_idx_d;
  logic [3:0]     digit_q, digit_d;
  logic [15:0]    max_score_q, max_score_d;
  logic           timeout_err_q, timeout_err_d;
  logic           take_new;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StError: if (start) state_d = StIssue;
      StIssue:         state_d = StWait;
      StWait: begin
        // A row completing on the final watchdog cycle wins over the timeout.
        if (done_row) begin
          state_d = StCompare;
        end else if (wdog_q == WdMax) begin
          state_d = StError;
        end
      end
      StCompare:       state_d = (row_idx_q == LastRow) ? StDone : StIssue;
      StDone:          state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    begin_mult   = (state_q == StIssue);
    result_valid = (state_q == StDone);
    busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StCompare);
  end

  // Strict signed compare so ties keep the lower row index.
  assign take_new = (row_idx_q == 4'd0) || ($signed(score_q) > $signed(best_score_q));

  always_comb begin
    row_idx_d     = row_idx_q;
    wdog_d        = wdog_q;
    score_d       = score_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    digit_d       = digit_q;
    max_score_d   = max_score_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          row_idx_d     = 4'd0;
          timeout_err_d = 1'b0;
        end
      end
      StIssue: wdog_d = '0;
      StWait: begin
        if (done_row) begin
          score_d = row_result;
        end else if (wdog_q == WdMax) begin
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StCompare: begin
        if (take_new) begin
          best_score_d = score_q;
          best_idx_d   = row_idx_q;
        end
        // Publish on the edge into DONE so the outputs line up with result_valid.
        if (row_idx_q == LastRow) begin
          digit_d     = take_new ? row_idx_q : best_idx_q;
          max_score_d = take_new ? score_q : best_score_q;
        end else begin
          row_idx_d = row_idx_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_idx_q     <= 4'd0;
      wdog_q        <= '0;
      score_q       <= 16'd0;
      best_score_q  <= 16'd0;
      best_idx_q    <= 4'd0;
      digit_q       <= 4'd0;
      max_score_q   <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      row_idx_q     <= row_idx_d;
      wdog_q        <= wdog_d;
      score_q       <= score_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      digit_q       <= digit_d;
      max_score_q   <= max_score_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign row_select  = row_idx_q;
  assign digit       = digit_q;
  assign max_score   = max_score_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_digit_classifier.sv
// Bench for digit_classifier: table of classification runs plus hand-built timeout,
// spurious-pulse and mid-run reset sequences, with a queue of expected results.
module tb_digit_classifier;

  localparam int NUM_ROWS = 10;
  localparam int TIMEOUT  = 20;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        done_row;
  logic [15:0] row_result;
  logic        begin_mult;
  logic [3:0]  row_select;
  logic        busy;
  logic        result_valid;
  logic [3:0]  digit;
  logic [15:0] max_score;
  logic        timeout_err;

  digit_classifier #(
    .NUM_ROWS(NUM_ROWS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .done_row    (done_row),
    .row_result  (row_result),
    .begin_mult  (begin_mult),
    .row_select  (row_select),
    .busy        (busy),
    .result_valid(result_valid),
    .digit       (digit),
    .max_score   (max_score),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [0:9][15:0] scores;
    int               delay;
    logic [3:0]       exp_digit;
    logic [15:0]      exp_score;
  } vec_t;

  typedef struct packed {
    logic [3:0]  d;
    logic [15:0] s;
  } exp_t;

  vec_t        vecs [6];
  exp_t        exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          bm_cnt = 0;
  int          rv_cnt = 0;
  logic [3:0]  last_digit = 4'd0;
  logic [15:0] last_score = 16'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (begin_mult) bm_cnt <= bm_cnt + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  function automatic vec_t mk(input logic [0:9][15:0] s, input int d, input logic [3:0] dg,
                              input logic [15:0] sc);
    vec_t v;
    v.scores = s;
    v.delay = d;
    v.exp_digit = dg;
    v.exp_score = sc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bm(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (begin_mult) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("begin_mult_seen", {31'd0, begin_mult}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int xstart_row, input int stall_row,
                         input int reset_row);
    int bm0;
    int rv0;
    bit ok;
    bit seen;
    exp_t e;
    bm0 = bm_cnt;
    rv0 = rv_cnt;
    if (stall_row < 0 && reset_row < 0) exp_q.push_back({v.exp_digit, v.exp_score});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_cleared_on_start", {31'd0, timeout_err}, 32'd0);
    for (int r = 0; r < NUM_ROWS; r++) begin
      wait_bm(ok);
      if (!ok) return;
      chk("row_select_issue", {28'd0, row_select}, r);
      if (r == stall_row) begin
        for (int k = 1; k <= TIMEOUT + 1; k++) step();
        chk("err_before_timeout", {31'd0, timeout_err}, 32'd0);
        chk("busy_last_wait", {31'd0, busy}, 32'd1);
        step();
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        chk("busy_in_error", {31'd0, busy}, 32'd0);
        chk("digit_kept_on_err", {28'd0, digit}, {28'd0, last_digit});
        chk("score_kept_on_err", {16'd0, max_score}, {16'd0, last_score});
        return;
      end
      if (r == reset_row) begin
        step();
        #3 n_rst = 1'b0;
        #1;
        chk("outputs_zero_in_reset",
            {4'd0, begin_mult, row_select, busy, result_valid, digit, max_score, timeout_err}, 0);
        step();
        chk("outputs_zero_held", {4'd0, begin_mult, row_select, busy, result_valid, digit,
                                  max_score, timeout_err}, 0);
        n_rst = 1'b1;
        last_digit = 4'd0;
        last_score = 16'd0;
        return;
      end
      for (int k = 1; k <= v.delay; k++) begin
        step();
        chk("row_select_stable", {28'd0, row_select}, r);
        start = (r == xstart_row) && (k == 1);
        done_row = (k == v.delay);
        if (k == v.delay) row_result = v.scores[r];
      end
      step();
      chk("row_select_compare", {28'd0, row_select}, r);
      done_row = 1'b0;
      start = 1'b0;
      row_result = 16'($urandom);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("result_valid_seen", {31'd0, seen}, 32'd1);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("digit", {28'd0, digit}, {28'd0, e.d});
      chk("max_score", {16'd0, max_score}, {16'd0, e.s});
      last_digit = e.d;
      last_score = e.s;
    end
    step();
    chk("result_valid_one_cycle", {31'd0, result_valid}, 32'd0);
    chk("busy_after_run", {31'd0, busy}, 32'd0);
    chk("timeout_err_clear", {31'd0, timeout_err}, 32'd0);
    chk("begin_mult_count", bm_cnt - bm0, NUM_ROWS);
    chk("result_valid_count", rv_cnt - rv0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = mk({16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd1, 16'd2, 16'd8, 16'd7, 16'd4},
                 3, 4'd1, 16'd9);
    vecs[1] = mk({16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3, 16'hFFF4, 16'hFFF5, 16'hFFFF,
                  16'hFFF6, 16'hFFF7, 16'hFFF8}, 2, 4'd6, 16'hFFFF);
    vecs[2] = mk({10{16'h1234}}, 1, 4'd0, 16'h1234);
    vecs[3] = mk({16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h7FFE}, 4, 4'd2, 16'h7FFF);
    vecs[4] = mk({16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10},
                 5, 4'd9, 16'd10);
    vecs[5] = mk({16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3},
                 TIMEOUT + 1, 4'd5, 16'd9);

    n_rst = 1'b0;
    start = 1'b0;
    done_row = 1'b0;
    row_result = 16'd0;
    #3;
    chk("reset_outputs", {4'd0, begin_mult, row_select, busy, result_valid, digit, max_score,
                          timeout_err}, 0);
    step();
    step();
    n_rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], -1, -1, -1);
      for (int k = 0; k < 3; k++) step();
      chk("digit_held", {28'd0, digit}, {28'd0, vecs[i].exp_digit});
      chk("score_held", {16'd0, max_score}, {16'd0, vecs[i].exp_score});
    end

    // Row 4 never completes; then a new start recovers.
    run_vec(vecs[0], -1, 4, -1);
    for (int k = 0; k < 4; k++) step();
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    // done_row arriving exactly as the watchdog expires.
    run_vec(vecs[5], -1, -1, -1);

    // Stray done_row in IDLE, then start pulsed during row 2 WAIT.
    done_row = 1'b1;
    row_result = 16'h7FFF;
    step();
    done_row = 1'b0;
    step();
    chk("stray_done_idle_busy", {31'd0, busy}, 32'd0);
    run_vec(vecs[0], 2, -1, -1);

    // Reset during row 5 WAIT, then a clean run from row 0.
    run_vec(vecs[1], -1, -1, 5);
    step();
    run_vec(vecs[3], -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
